// File: rtl/wb_gcd_accel_pkg.sv
// gcd_pkg: shared types and constants for the Wishbone GCD accelerator.
//   state_t     - engine states (IDLE, CALC, DONE)
//   OFS_*       - register byte offsets inside the 256-byte window
//   CTRL_*/STAT_* - bit positions inside CTRL and STATUS
//   merge_lanes - byte-lane write merge used for OPA/OPB
package gcd_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [7:0] OFS_OPA    = 8'h00;
    localparam logic [7:0] OFS_OPB    = 8'h04;
    localparam logic [7:0] OFS_CTRL   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_RESULT = 8'h10;
    localparam logic [7:0] OFS_CYCLES = 8'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdat,
                                                input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_gcd_accel_if.sv
// wb_gcd_accel_if: Wishbone slave bus bundle for the GCD accelerator.
//   wbs_stb_i/cyc_i/we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0] - master to slave
//   wbs_ack_o, wbs_dat_o[31:0]                                             - slave to master
interface wb_gcd_accel_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_gcd_accel_core.sv
// gcd_core: subtractive GCD engine (a/b working registers, swap/subtract, cycle counter, FSM).
//   clk, rst_n      - clock, async active-low reset
//   start           - load opa/opb and begin (ignored while busy)
//   clear           - leave DONE for IDLE (start takes priority)
//   opa, opb        - operands sampled on an accepted start
//   busy, done      - state == CALC / state == DONE
//   result, cycles  - final GCD and number of CALC cycles (saturating)
module gcd_core
    import gcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] cycles
);

    state_t      state, state_nx;
    logic [31:0] a, b;

    assign busy = state == CALC;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CALC : IDLE;
            CALC:    state_nx = (b == '0) ? DONE : CALC;
            DONE:    state_nx = start ? CALC : (clear ? IDLE : DONE);
            default: state_nx = IDLE;
        endcase
    end

    // One step per CALC cycle; a>=b holds whenever we subtract, so no underflow.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            result <= '0;
            cycles <= '0;
        end else if (start && !busy) begin
            a      <= opa;
            b      <= opb;
            cycles <= '0;
        end else if (busy) begin
            cycles <= (&cycles) ? cycles : cycles + 32'd1;
            if (b == '0) result <= a;
            else if (a < b) begin
                a <= b;
                b <= a;
            end else a <= a - b;
        end

endmodule

// File: rtl/wb_gcd_accel.sv
// wb_gcd_accel: Wishbone-mapped GCD accelerator (bus decode, registers, irq).
//   wb_clk_i, wb_rst_ni - clock, async active-low reset
//   wb                  - Wishbone slave bundle (one-cycle registered ack)
//   irq_o               - registered DONE & IRQ_EN
module wb_gcd_accel
    import gcd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    wb_gcd_accel_if.slave  wb,
    output logic           irq_o
);

    logic [31:0] opa, opb, rdata, result, cycles;
    logic [7:0]  ofs;
    logic        irq_en, busy, done, req, wr, start, clear;
    logic        unused_adr;

    assign unused_adr = ^wb.wbs_adr_i[1:0];
    assign ofs   = {wb.wbs_adr_i[7:2], 2'b00};
    // Gating on ~ack forces an idle cycle between acks when stb is held.
    assign req   = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wb.wbs_ack_o;
    assign wr    = req & wb.wbs_we_i;
    assign start = wr && ofs == OFS_CTRL && wb.wbs_sel_i[0] && wb.wbs_dat_i[CTRL_START];
    assign clear = wr && ofs == OFS_STATUS && wb.wbs_sel_i[0] && wb.wbs_dat_i[STAT_DONE];

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_OPA:    rdata = opa;
            OFS_OPB:    rdata = opb;
            OFS_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
            OFS_STATUS: rdata[STAT_DONE:STAT_BUSY] = {done, busy};
            OFS_RESULT: rdata = result;
            OFS_CYCLES: rdata = cycles;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            irq_o        <= 1'b0;
            irq_en       <= 1'b0;
            opa          <= '0;
            opb          <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : '0;
            irq_o        <= done & irq_en;
            if (wr && ofs == OFS_OPA) opa <= merge_lanes(opa, wb.wbs_dat_i, wb.wbs_sel_i);
            if (wr && ofs == OFS_OPB) opb <= merge_lanes(opb, wb.wbs_dat_i, wb.wbs_sel_i);
            if (wr && ofs == OFS_CTRL && wb.wbs_sel_i[0]) irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
        end

    gcd_core u_core (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .start  (start),
        .clear  (clear),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cycles (cycles)
    );

endmodule

// File: tb/tb_wb_gcd_accel.sv
// tb_wb_gcd_accel: directed and randomized bench for wb_gcd_accel against a behavioural model.
module tb_wb_gcd_accel;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic irq;

    wb_gcd_accel_if bus_if();

    wb_gcd_accel #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb        (bus_if),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference GCD by the stated step rules: returns the result and the number of steps.
    function automatic void gcd_ref(input logic [31:0] a0, input logic [31:0] b0,
                                    output logic [31:0] r, output int n);
        logic [31:0] a = a0, b = b0, t;
        n = 0;
        forever begin
            n++;
            if (b == 0) break;
            if (a < b) begin t = a; a = b; b = t; end
            else a = a - b;
        end
        r = a;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_opa, m_opb, m_res, m_cyc, m_dat, p_res;
    logic        m_en, m_done, m_ack, m_irq;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin : model
        logic        req, busy;
        logic [7:0]  o;
        logic [31:0] rd, d, gr, mk;
        int          gn;
        if (!rst_n) begin
            m_opa <= 0; m_opb <= 0; m_res <= 0; m_cyc <= 0; m_dat <= 0; p_res <= 0;
            m_en <= 0; m_done <= 0; m_ack <= 0; m_irq <= 0; m_left <= 0;
        end else begin
            req  = bus_if.wbs_stb_i && bus_if.wbs_cyc_i && bus_if.wbs_adr_i[31:8] == BASE[31:8] && !m_ack;
            o    = {bus_if.wbs_adr_i[7:2], 2'b00};
            d    = bus_if.wbs_dat_i;
            mk   = lane_mask(bus_if.wbs_sel_i);
            busy = m_left > 0;
            rd   = o == 8'h00 ? m_opa : o == 8'h04 ? m_opb : o == 8'h08 ? {30'b0, m_en, 1'b0} :
                   o == 8'h0C ? {30'b0, m_done, busy} : o == 8'h10 ? m_res : o == 8'h14 ? m_cyc : 32'h0;
            m_ack <= req;
            m_dat <= (req && !bus_if.wbs_we_i) ? rd : 32'h0;
            m_irq <= m_done && m_en;
            if (busy) begin
                m_left <= m_left - 1;
                m_cyc  <= (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
                if (m_left == 1) begin m_done <= 1; m_res <= p_res; end
            end
            if (req && bus_if.wbs_we_i) begin
                if (o == 8'h00) m_opa <= (m_opa & ~mk) | (d & mk);
                if (o == 8'h04) m_opb <= (m_opb & ~mk) | (d & mk);
                if (o == 8'h08 && bus_if.wbs_sel_i[0]) begin
                    m_en <= d[1];
                    if (d[0] && !busy) begin
                        gcd_ref(m_opa, m_opb, gr, gn);
                        p_res <= gr; m_left <= gn; m_cyc <= 0; m_done <= 0;
                    end
                end
                if (o == 8'h0C && bus_if.wbs_sel_i[0] && d[1] && !busy) m_done <= 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) if (rst_n) begin
        chk("ack", {31'b0, bus_if.wbs_ack_o}, {31'b0, m_ack});
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        if (m_ack) chk("rdata", bus_if.wbs_dat_o, m_dat);
    end

    // ---------------- bus helpers ----------------
    task automatic bus(input logic we, input logic [7:0] ofs, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q);
        bit got = 0;
        @(negedge clk);
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_we_i = we;
        bus_if.wbs_adr_i = BASE + {24'h0, ofs}; bus_if.wbs_dat_i = d; bus_if.wbs_sel_i = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus_if.wbs_ack_o) begin got = 1; break; end
        end
        q = bus_if.wbs_dat_o;
        if (!got) begin
            checks++; errors++;
            $display("FAIL bus_timeout: ofs %h got no ack required ack within 4 cycles", ofs);
        end
        @(negedge clk);
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0; bus_if.wbs_we_i = 0;
    endtask

    task automatic wait_done(input string nm);
        logic [31:0] s;
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            bus(0, 8'h0C, 0, 4'hF, s);
            if (s[1]) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s: DONE=0 after 400 polls required DONE=1", nm); end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic [4:0]  pat;
        logic        acc;
        logic [31:0] ba[3] = '{32'd0, 32'd7, 32'd0};
        logic [31:0] bb[3] = '{32'd0, 32'd0, 32'd9};
        logic [31:0] br[3] = '{32'd0, 32'd7, 32'd9};
        logic [31:0] bc[3] = '{32'd1, 32'd1, 32'd2};
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0; bus_if.wbs_we_i = 0;
        bus_if.wbs_sel_i = 0; bus_if.wbs_adr_i = 0; bus_if.wbs_dat_i = 0;
        #1 rst_n = 0;
        #2;
        chk("reset_ack", {31'b0, bus_if.wbs_ack_o}, 0);
        chk("reset_dat", bus_if.wbs_dat_o, 0);
        chk("reset_irq", {31'b0, irq}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        bus(0, 8'h0C, 0, 4'hF, q); chk("reset_status", q, 0);
        bus(0, 8'h00, 0, 4'hF, q); chk("reset_opa", q, 0);

        // GCD(12,8)
        bus(1, 8'h00, 12, 4'hF, q);
        bus(1, 8'h04, 8, 4'hF, q);
        bus(1, 8'h08, 1, 4'hF, q);
        bus(0, 8'h0C, 0, 4'hF, q); chk("busy_after_start", q, 1);
        wait_done("gcd_12_8_done");
        bus(0, 8'h10, 0, 4'hF, q); chk("gcd_12_8_result", q, 4);
        bus(0, 8'h14, 0, 4'hF, q); chk("gcd_12_8_cycles", q, 6);
        bus(0, 8'h0C, 0, 4'hF, q); chk("gcd_12_8_status", q, 2);

        // Boundary operands
        for (int i = 0; i < 3; i++) begin
            bus(1, 8'h00, ba[i], 4'hF, q);
            bus(1, 8'h04, bb[i], 4'hF, q);
            bus(1, 8'h08, 1, 4'hF, q);
            wait_done("boundary_done");
            bus(0, 8'h10, 0, 4'hF, q); chk("boundary_result", q, br[i]);
            bus(0, 8'h14, 0, 4'hF, q); chk("boundary_cycles", q, bc[i]);
        end

        // Interrupt path with GCD(48,18)
        bus(1, 8'h08, 2, 4'hF, q);
        bus(1, 8'h00, 48, 4'hF, q);
        bus(1, 8'h04, 18, 4'hF, q);
        bus(1, 8'h08, 3, 4'hF, q);
        wait_done("gcd_48_18_done");
        bus(0, 8'h10, 0, 4'hF, q); chk("gcd_48_18_result", q, 6);
        @(posedge clk); #1 chk("irq_high", {31'b0, irq}, 1);
        bus(1, 8'h0C, 2, 4'h1, q);
        @(posedge clk); #1 chk("irq_low_after_w1c", {31'b0, irq}, 0);
        bus(0, 8'h0C, 0, 4'hF, q); chk("idle_after_w1c", q, 0);

        // Operand rewrite and START during CALC
        bus(1, 8'h00, 12, 4'hF, q);
        bus(1, 8'h04, 8, 4'hF, q);
        bus(1, 8'h08, 3, 4'hF, q);
        bus(1, 8'h00, 100, 4'hF, q);
        bus(1, 8'h08, 3, 4'hF, q);
        wait_done("rewrite_done");
        bus(0, 8'h10, 0, 4'hF, q); chk("rewrite_result", q, 4);
        bus(0, 8'h00, 0, 4'hF, q); chk("rewrite_opa", q, 100);
        bus(1, 8'h0C, 2, 4'h1, q);

        // stb held for 5 cycles: acks alternate
        @(negedge clk);
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_we_i = 0; bus_if.wbs_adr_i = BASE;
        pat = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); pat = {pat[3:0], bus_if.wbs_ack_o}; end
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0;
        chk("ack_alternate", {27'b0, pat}, 32'h15);

        // Unmapped offset inside and address outside the window
        bus(0, 8'h20, 0, 4'hF, q); chk("unmapped_read", q, 0);
        @(negedge clk);
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_adr_i = BASE + 32'h100;
        acc = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); acc |= bus_if.wbs_ack_o; end
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0;
        chk("out_of_window_ack", {31'b0, acc}, 0);

        // Partial lane write
        bus(1, 8'h00, 32'hAAAA_AAAA, 4'hF, q);
        bus(1, 8'h00, 32'h1234_5678, 4'b0011, q);
        bus(0, 8'h00, 0, 4'hF, q); chk("sel_0011_opa", q, 32'hAAAA_5678);

        // Randomized traffic, checked every cycle by the model
        bus(1, 8'h00, 30, 4'hF, q);
        bus(1, 8'h04, 45, 4'hF, q);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: bus(1, 8'h00, $urandom_range(0, 255), 4'hF, q);
                1: bus(1, 8'h04, $urandom_range(0, 255), 4'hF, q);
                2: bus(1, 8'h08, $urandom_range(0, 3), 4'($urandom_range(0, 15)), q);
                3: bus(1, 8'h0C, $urandom_range(0, 3), 4'($urandom_range(0, 15)), q);
                4: bus(0, {6'($urandom_range(0, 63)), 2'b00}, 0, 4'hF, q);
                default: repeat ($urandom_range(1, 4)) @(negedge clk);
            endcase
        end

        // Reset mid-CALC and mid-ack
        bus(1, 8'h00, 200, 4'hF, q);
        bus(1, 8'h04, 3, 4'hF, q);
        bus(1, 8'h08, 3, 4'hF, q);
        @(negedge clk);
        bus_if.wbs_stb_i = 1; bus_if.wbs_cyc_i = 1; bus_if.wbs_we_i = 0; bus_if.wbs_adr_i = BASE + 32'h0C;
        @(posedge clk); #1 chk("ack_before_reset", {31'b0, bus_if.wbs_ack_o}, 1);
        #1 rst_n = 0;
        #1;
        chk("midreset_ack", {31'b0, bus_if.wbs_ack_o}, 0);
        chk("midreset_dat", bus_if.wbs_dat_o, 0);
        chk("midreset_irq", {31'b0, irq}, 0);
        @(negedge clk);
        bus_if.wbs_stb_i = 0; bus_if.wbs_cyc_i = 0;
        @(negedge clk) rst_n = 1;
        repeat (2) @(negedge clk);
        bus(0, 8'h0C, 0, 4'hF, q); chk("status_after_reset", q, 0);
        repeat (10) @(negedge clk);
        chk("no_irq_after_reset", {31'b0, irq}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
